// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux output among four requesters,
// with a per-grant hold limit so no requester can starve the others.
module rr_mux4_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] i,
  output logic [1:0] s,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       y
);

  // state | meaning
  // IDLE  | no grant outstanding, gnt=0, busy=0
  // GRANT | one requester owns the mux, hold counter running
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    r_state;
  logic [1:0]    r_last;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_s;
  logic [3:0]    r_gnt;
  logic          r_busy;

  logic [1:0]    w_win;
  logic          w_found;
  logic          w_release;

  // While granted, r_last equals r_s, so one search from r_last+1 serves
  // both the idle pick and the back-to-back re-pick on release.
  always_comb begin
    logic [1:0] idx;
    w_win   = r_last;
    w_found = 1'b0;
    idx     = r_last;
    for (int k = 1; k <= 4; k++) begin
      idx = r_last + 2'(k);
      if (!w_found && req[idx]) begin
        w_win   = idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_release = (r_state == GRANT) &&
                     (!req[r_s] || (r_cnt == CW'(MAX_HOLD - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
      r_cnt   <= '0;
      r_s     <= 2'd0;
      r_gnt   <= 4'b0000;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= GRANT;
            r_last  <= w_win;
            r_s     <= w_win;
            r_gnt   <= 4'b0001 << w_win;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        GRANT: begin
          if (w_release) begin
            if (w_found) begin
              r_last <= w_win;
              r_s    <= w_win;
              r_gnt  <= 4'b0001 << w_win;
              r_cnt  <= '0;
            end else begin
              r_state <= IDLE;
              r_gnt   <= 4'b0000;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
            end
          end else if (r_cnt != CW'(MAX_HOLD - 1)) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 4'b0000;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign s    = r_s;
  assign gnt  = r_gnt;
  assign busy = r_busy;
  assign y    = r_busy ? i[r_s] : 1'b0;

endmodule
